pe_array_sched: RTL and testbench
=================================

# pe_array_sched

Pass-level sequencer for a column of `pe_top` instances. It issues the one-cycle start pulses (`start_config`, weight, feature and psum-in load, psum drain) in order. It counts accepted bus words against programmed lengths, waits for every PE's `mac_finish`, and repeats for a programmed number of passes. It sits between the global-buffer/bus controller and the PE array, and gates bus-side ready so that words move only in the matching phase.

## Interface
Parameters:
- `NUM_PE`, 12, number of PEs sequenced
- `CNT_WIDTH`, 16, width of word and pass counters

Ports:
- `clk` in 1: the block's single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle request to run a job; sampled only in IDLE
- `abort` in 1: synchronous abort; forces IDLE next cycle
- `num_pass` in CNT_WIDTH: passes per job; 0 is treated as 1
- `w_len`, `if_len`, `psum_len` in CNT_WIDTH each: weight, ifmap and psum-in words per pass
- `out_len` in CNT_WIDTH: psum-out words expected per pass
- `pe_weight_load_ready`, `pe_ifmap_load_ready`, `pe_psum_in_load_ready` in NUM_PE each: per-PE ready
- `mac_finish` in NUM_PE: per-PE level/pulse
- `bus_weight_valid`, `bus_feature_valid`, `bus_psum_in_valid`, `bus_psum_out_valid` in 1 each
- `start_config`, `start_weight_load`, `start_feature_load`, `start_psum_in_load`, `psum_out_start` out 1 each: start pulses
- `weight_ready`, `feature_ready`, `psum_in_ready` out 1 each: bus-side accept
- `busy` out 1: job in progress
- `done` out 1: one-cycle job-complete pulse
- `pass_idx` out CNT_WIDTH: current pass number
- `state` out 3: encoded state, for debug

## Operation
- States: IDLE, CONFIG, LOAD_W, LOAD_IF, LOAD_PSUM, WAIT_MAC, DRAIN.
- IDLE → CONFIG on `start`.
- CONFIG lasts 1 cycle, with `start_config`=1. It clears `pass_idx` and the counters, then goes to LOAD_W.
- LOAD_W:
  - `start_weight_load`=1 on the first cycle only.
  - `weight_ready` = `&pe_weight_load_ready` while in state.
  - A word is accepted when `bus_weight_valid & weight_ready`; accepted words increment `wcnt`.
  - Exits to LOAD_IF on the cycle the accept makes `wcnt`=`w_len`.
- LOAD_IF: identical to LOAD_W, using the feature signals and `if_len`.
  - Exits to LOAD_PSUM if `pass_idx`≠0, else to WAIT_MAC.
- LOAD_PSUM: identical scheme, using the psum-in signals and `psum_len`. Exits to WAIT_MAC.
- WAIT_MAC:
  - Sticky vector `fin` |= `mac_finish` each cycle; `fin` is cleared on entry.
  - Exits to DRAIN when `&(fin | mac_finish)`=1, so a same-cycle final bit counts.
- DRAIN:
  - `psum_out_start`=1 on the first cycle only.
  - `ocnt` counts `bus_psum_out_valid`.
  - When `ocnt` reaches `out_len`:
    - if `pass_idx`=`max(num_pass,1)`−1: go to IDLE and pulse `done`;
    - else increment `pass_idx` and go to LOAD_W.
- Zero length (`w_len`/`if_len`/`psum_len`/`out_len`=0): the state lasts exactly 1 cycle. Its start pulse is still issued and its ready stays 0.
- Ready outputs are 0 outside their own state. Valid words arriving then are ignored and not counted.
- Counters saturate at their target; extra beats are never counted.
- `abort` takes priority over every transition. It deasserts all outputs next cycle; `done` is not pulsed.
- `start` while busy is ignored.
- Reset mid-operation → IDLE immediately, all outputs 0.

## Timing
- Reset values: every output 0, `state`=IDLE, `pass_idx`=0.
- State is registered. Outputs are Moore-decoded from state plus the first-cycle flag (a registered `entry` bit); ready is `&ready_vec` gated by state, combinational from the inputs.
- `start` at cycle t → `start_config` at t+1 → `start_weight_load` at t+2.
- The last accepted word at cycle t → next state's pulse at t+1. No idle bubble between phases.
- `done` is asserted during the last DRAIN cycle's successor (t+1), with `busy`=0 in that same cycle.
- `busy`=1 in every state except IDLE.

## Structure
- Package `pe_sched_pkg` holds the state encodings (IDLE=0 … DRAIN=6) and the state width constant 3.
- Sub-module `sched_word_cnt`: a clearable, saturating counter with `inc`, `target`, `hit` outputs. It is instantiated once, shared across load/drain phases and cleared on each state entry.
- `fin` vector and pass counter stay in the top.

## Test plan
- NUM_PE=4, num_pass=1, w_len=3, if_len=2, out_len=2, valid always 1, all ready=1 → states CONFIG(1), LOAD_W(3), LOAD_IF(2), WAIT_MAC, DRAIN(2); `done` 1 cycle; LOAD_PSUM skipped.
- Same job with `pe_weight_load_ready[2]`=0 for cycles 2–5 of LOAD_W → `weight_ready`=0 then, `wcnt` frozen, LOAD_W extended by 4 cycles.
- num_pass=3, psum_len=4 → LOAD_PSUM entered only in passes 1 and 2; `pass_idx` steps 0,1,2; a single `done`.
- `mac_finish` bits arrive as staggered single-cycle pulses on PEs 0,3,1,2 → DRAIN entered the cycle after bit 2; `fin` clears on the next WAIT_MAC entry.
- w_len=0 → LOAD_W lasts 1 cycle, `start_weight_load` pulses, `weight_ready` stays 0; num_pass=0 behaves as 1.
- `abort` during LOAD_IF, then `rst_n` low mid-DRAIN in a second job → IDLE in the next cycle / immediately, all outputs 0, no `done`; a later `start` runs normally.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE-array pass sequencer.
// The state encoding is visible on the debug port, so the values are fixed.
package pe_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    CONFIG    = 3'd1,
    LOAD_W    = 3'd2,
    LOAD_IF   = 3'd3,
    LOAD_PSUM = 3'd4,
    WAIT_MAC  = 3'd5,
    DRAIN     = 3'd6
  } state_t;

endpackage

// File: rtl/pe_array_sched_if.sv
// Bus-side handshake between the global-buffer controller and the sequencer.
// The controller offers words; the sequencer accepts them only in the matching phase.
interface pe_array_sched_if;

  logic bus_weight_valid;
  logic bus_feature_valid;
  logic bus_psum_in_valid;
  logic bus_psum_out_valid;
  logic weight_ready;
  logic feature_ready;
  logic psum_in_ready;

  modport master (
    output bus_weight_valid, bus_feature_valid, bus_psum_in_valid, bus_psum_out_valid,
    input  weight_ready, feature_ready, psum_in_ready
  );

  modport slave (
    input  bus_weight_valid, bus_feature_valid, bus_psum_in_valid, bus_psum_out_valid,
    output weight_ready, feature_ready, psum_in_ready
  );

endinterface

// File: rtl/sched_word_cnt.sv
// Clearable word counter that saturates at its target.
// hit means "this phase is complete after the current cycle" and covers a zero target.
module sched_word_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic             hit
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH:0]   count_inc;

  // One bit wider, so a target of all-ones still compares correctly.
  assign count_inc = {1'b0, count_reg} + (WIDTH+1)'(1);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != target)) begin
      count_next = count_inc[WIDTH-1:0];
    end
  end

  assign hit = (count_reg == target) || (inc && (count_inc == {1'b0, target}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pe_array_sched.sv
// Pass-level sequencer for a column of PEs: issues phase start pulses, gates bus
// ready per phase, counts words, collects mac_finish and repeats for num_pass passes.
module pe_array_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE    = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] num_pass,
  input  logic [CNT_WIDTH-1:0] w_len,
  input  logic [CNT_WIDTH-1:0] if_len,
  input  logic [CNT_WIDTH-1:0] psum_len,
  input  logic [CNT_WIDTH-1:0] out_len,
  input  logic [NUM_PE-1:0]    pe_weight_load_ready,
  input  logic [NUM_PE-1:0]    pe_ifmap_load_ready,
  input  logic [NUM_PE-1:0]    pe_psum_in_load_ready,
  input  logic [NUM_PE-1:0]    mac_finish,
  pe_array_sched_if.slave      bus,
  output logic                 start_config,
  output logic                 start_weight_load,
  output logic                 start_feature_load,
  output logic                 start_psum_in_load,
  output logic                 psum_out_start,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pass_idx,
  output logic [STATE_W-1:0]   state
);

  state_t               state_reg, state_next;
  logic                 entry_reg;
  logic                 done_reg, done_set;
  logic [CNT_WIDTH-1:0] pass_idx_reg, pass_idx_next;
  logic [NUM_PE-1:0]    fin_reg, fin_next;
  logic                 all_fin;
  logic                 last_pass;
  logic                 cnt_clr, cnt_inc, cnt_hit;
  logic [CNT_WIDTH-1:0] cnt_target;
  logic                 fin_clear;

  // A zero-length phase still runs one cycle but never offers ready.
  assign bus.weight_ready  = (state_reg == LOAD_W)    && (&pe_weight_load_ready)  && (w_len    != '0);
  assign bus.feature_ready = (state_reg == LOAD_IF)   && (&pe_ifmap_load_ready)   && (if_len   != '0);
  assign bus.psum_in_ready = (state_reg == LOAD_PSUM) && (&pe_psum_in_load_ready) && (psum_len != '0);

  assign last_pass = (num_pass == '0) ? (pass_idx_reg == '0)
                                      : (pass_idx_reg == num_pass - CNT_WIDTH'(1));

  // Sticky finish flags; the combinational OR lets a same-cycle final pulse count.
  assign fin_clear = (state_next == WAIT_MAC) && (state_reg != WAIT_MAC);
  assign all_fin   = &(fin_reg | mac_finish);

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_fin
    assign fin_next[gi] = fin_clear ? 1'b0
                        : (state_reg == WAIT_MAC) ? (fin_reg[gi] | mac_finish[gi])
                        : fin_reg[gi];
  end

  always_comb begin
    state_next         = state_reg;
    pass_idx_next      = pass_idx_reg;
    done_set           = 1'b0;
    cnt_inc            = 1'b0;
    cnt_target         = '0;
    start_config       = 1'b0;
    start_weight_load  = 1'b0;
    start_feature_load = 1'b0;
    start_psum_in_load = 1'b0;
    psum_out_start     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) state_next = CONFIG;
      end
      CONFIG: begin
        start_config  = 1'b1;
        pass_idx_next = '0;
        state_next    = LOAD_W;
      end
      LOAD_W: begin
        start_weight_load = entry_reg;
        cnt_inc           = bus.bus_weight_valid & bus.weight_ready;
        cnt_target        = w_len;
        if (cnt_hit) state_next = LOAD_IF;
      end
      LOAD_IF: begin
        start_feature_load = entry_reg;
        cnt_inc            = bus.bus_feature_valid & bus.feature_ready;
        cnt_target         = if_len;
        if (cnt_hit) state_next = (pass_idx_reg != '0) ? LOAD_PSUM : WAIT_MAC;
      end
      LOAD_PSUM: begin
        start_psum_in_load = entry_reg;
        cnt_inc            = bus.bus_psum_in_valid & bus.psum_in_ready;
        cnt_target         = psum_len;
        if (cnt_hit) state_next = WAIT_MAC;
      end
      WAIT_MAC: begin
        if (all_fin) state_next = DRAIN;
      end
      DRAIN: begin
        psum_out_start = entry_reg;
        cnt_inc        = bus.bus_psum_out_valid;
        cnt_target     = out_len;
        if (cnt_hit) begin
          if (last_pass) begin
            state_next    = IDLE;
            pass_idx_next = '0;
            done_set      = 1'b1;
          end else begin
            state_next    = LOAD_W;
            pass_idx_next = pass_idx_reg + CNT_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next    = IDLE;
      pass_idx_next = '0;
      done_set      = 1'b0;
    end
  end

  // Every state change restarts the shared counter, so each phase starts from zero.
  assign cnt_clr = (state_next != state_reg);

  sched_word_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_word_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .target (cnt_target),
    .hit    (cnt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      entry_reg    <= 1'b0;
      done_reg     <= 1'b0;
      pass_idx_reg <= '0;
      fin_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      entry_reg    <= (state_next != state_reg);
      done_reg     <= done_set;
      pass_idx_reg <= pass_idx_next;
      fin_reg      <= fin_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign pass_idx = pass_idx_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_pe_array_sched.sv
// Bench for pe_array_sched: table-driven jobs checked cycle by cycle against a
// queue of expected observations, plus hand-written stall, finish, abort and reset sequences.
module tb_pe_array_sched;
  import pe_sched_pkg::*;

  localparam int NPE = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_pass = '0, w_len = '0, if_len = '0, psum_len = '0, out_len = '0;
  logic [NPE-1:0] pe_weight_load_ready = '1, pe_ifmap_load_ready = '1, pe_psum_in_load_ready = '1;
  logic [NPE-1:0] mac_finish = '1;
  logic          start_config, start_weight_load, start_feature_load, start_psum_in_load, psum_out_start;
  logic          busy, done;
  logic [CW-1:0] pass_idx;
  logic [2:0]    state;

  pe_array_sched_if bus_if ();

  always #5 clk = ~clk;

  pe_array_sched #(.NUM_PE(NPE), .CNT_WIDTH(CW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .abort                 (abort),
    .num_pass              (num_pass),
    .w_len                 (w_len),
    .if_len                (if_len),
    .psum_len              (psum_len),
    .out_len               (out_len),
    .pe_weight_load_ready  (pe_weight_load_ready),
    .pe_ifmap_load_ready   (pe_ifmap_load_ready),
    .pe_psum_in_load_ready (pe_psum_in_load_ready),
    .mac_finish            (mac_finish),
    .bus                   (bus_if),
    .start_config          (start_config),
    .start_weight_load     (start_weight_load),
    .start_feature_load    (start_feature_load),
    .start_psum_in_load    (start_psum_in_load),
    .psum_out_start        (psum_out_start),
    .busy                  (busy),
    .done                  (done),
    .pass_idx              (pass_idx),
    .state                 (state)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          sc, sw, sf, sp, po, wr, fr, pr, busy, done;
    logic [CW-1:0] pidx;
  } obs_t;

  typedef struct {
    int np, w, i, ps, o;
    int exp_cycles;
  } vec_t;

  obs_t sb[$];
  vec_t tbl[4];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.st   = state;
    o.sc   = start_config;
    o.sw   = start_weight_load;
    o.sf   = start_feature_load;
    o.sp   = start_psum_in_load;
    o.po   = psum_out_start;
    o.wr   = bus_if.weight_ready;
    o.fr   = bus_if.feature_ready;
    o.pr   = bus_if.psum_in_ready;
    o.busy = busy;
    o.done = done;
    o.pidx = pass_idx;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected observations for one phase, assuming every PE ready and every bus valid is held at 1.
  task automatic push_phase(input state_t s, input int len, input int pidx);
    obs_t e;
    int   n;
    n = (len == 0) ? 1 : len;
    for (int k = 0; k < n; k++) begin
      e      = '0;
      e.st   = s;
      e.busy = 1'b1;
      e.pidx = CW'(pidx);
      case (s)
        CONFIG:    e.sc = 1'b1;
        LOAD_W:    begin e.sw = (k == 0); e.wr = (len != 0); end
        LOAD_IF:   begin e.sf = (k == 0); e.fr = (len != 0); end
        LOAD_PSUM: begin e.sp = (k == 0); e.pr = (len != 0); end
        DRAIN:     e.po = (k == 0);
        default:   ;
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic build_trace(input vec_t v);
    obs_t e;
    int   np_eff;
    np_eff = (v.np == 0) ? 1 : v.np;
    push_phase(CONFIG, 1, 0);
    for (int p = 0; p < np_eff; p++) begin
      push_phase(LOAD_W, v.w, p);
      push_phase(LOAD_IF, v.i, p);
      if (p > 0) push_phase(LOAD_PSUM, v.ps, p);
      push_phase(WAIT_MAC, 1, p);
      push_phase(DRAIN, v.o, p);
    end
    e      = '0;
    e.st   = IDLE;
    e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic set_job(input vec_t v);
    num_pass = CW'(v.np);
    w_len    = CW'(v.w);
    if_len   = CW'(v.i);
    psum_len = CW'(v.ps);
    out_len  = CW'(v.o);
  endtask

  task automatic drive_all_ready(input logic vld);
    pe_weight_load_ready  = '1;
    pe_ifmap_load_ready   = '1;
    pe_psum_in_load_ready = '1;
    bus_if.bus_weight_valid   = vld;
    bus_if.bus_feature_valid  = vld;
    bus_if.bus_psum_in_valid  = vld;
    bus_if.bus_psum_out_valid = vld;
  endtask

  // Leaves the bench at negedge+1 of the CONFIG cycle.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
  endtask

  task automatic wait_state(input state_t s, input int bound, input string name);
    int n = 0;
    while (state !== s && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_job(input vec_t v, input string name);
    obs_t e;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    set_job(v);
    drive_all_ready(1'b1);
    mac_finish = '1;
    build_trace(v);
    pulse_start();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_trace"}, 32'(sample()), 32'(e));
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (sb.size() > 0) begin
        @(negedge clk); #1;
      end
    end
    check({name, "_cycles"}, busy_cnt, v.exp_cycles);
    check({name, "_dones"}, done_cnt, 1);
    @(negedge clk); #1;
    check({name, "_done_clr"}, 32'(done), 32'd0);
    $display("job %s np=%0d w=%0d if=%0d ps=%0d out=%0d busy_cycles=%0d", name, v.np, v.w, v.i, v.ps, v.o, busy_cnt);
  endtask

  initial begin
    int pat[5];
    int k;
    vec_t v;

    tbl[0] = '{np: 1, w: 3, i: 2, ps: 0, o: 2, exp_cycles: 9};
    tbl[1] = '{np: 3, w: 2, i: 1, ps: 4, o: 1, exp_cycles: 24};
    tbl[2] = '{np: 0, w: 0, i: 1, ps: 0, o: 0, exp_cycles: 5};
    tbl[3] = '{np: 2, w: 0, i: 0, ps: 0, o: 3, exp_cycles: 14};

    drive_all_ready(1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'(sample()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_after_reset", 32'(sample()), 32'd0);

    for (int t = 0; t < 4; t++) begin
      run_job(tbl[t], $sformatf("tbl%0d", t));
    end

    // Weight ready withheld by PE 2 during LOAD_W cycles 2..5.
    set_job(tbl[0]);
    drive_all_ready(1'b1);
    mac_finish = '1;
    pulse_start();
    wait_state(LOAD_W, 5, "stall_enter");
    k = 1;
    while (state === LOAD_W && k < 50) begin
      pe_weight_load_ready = (k >= 2 && k <= 5) ? 4'b1011 : 4'b1111;
      #1;
      check("stall_wready", 32'(bus_if.weight_ready), 32'(!(k >= 2 && k <= 5)));
      @(negedge clk); #1;
      k++;
    end
    pe_weight_load_ready = '1;
    check("stall_len", k - 1, 7);
    check("stall_next", 32'(state), 32'(LOAD_IF));
    wait_done(40, "stall_done");
    $display("seq stall: LOAD_W lasted %0d cycles", k - 1);

    // Staggered single-cycle finish pulses on PEs 0,3,1,2.
    v = '{np: 2, w: 1, i: 1, ps: 1, o: 1, exp_cycles: 0};
    set_job(v);
    mac_finish = '0;
    pulse_start();
    wait_state(WAIT_MAC, 10, "mac_enter");
    pat = '{1, 0, 8, 2, 4};
    for (int j = 0; j < 5; j++) begin
      mac_finish = NPE'(pat[j]);
      #1;
      check("mac_wait", 32'(state), 32'(WAIT_MAC));
      @(negedge clk); #1;
    end
    mac_finish = '0;
    check("mac_drain", 32'(state), 32'(DRAIN));
    wait_state(WAIT_MAC, 20, "mac_reenter");
    check("mac_pass1", 32'(pass_idx), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check("fin_cleared", 32'(state), 32'(WAIT_MAC));
    end
    mac_finish = '1;
    @(negedge clk); #1;
    check("mac_drain2", 32'(state), 32'(DRAIN));
    wait_done(20, "mac_done");
    $display("seq staggered mac_finish: two passes completed");

    // Abort in LOAD_IF: idle next cycle, no done.
    set_job(tbl[0]);
    drive_all_ready(1'b1);
    pulse_start();
    wait_state(LOAD_IF, 10, "abort_enter");
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'(sample()), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    $display("seq abort: outputs cleared");

    // Reset mid-DRAIN: idle immediately.
    v = '{np: 1, w: 1, i: 1, ps: 0, o: 5, exp_cycles: 0};
    set_job(v);
    pulse_start();
    wait_state(DRAIN, 20, "rst_enter");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check("reset_no_done", 32'({state, done}), 32'd0);
    end
    $display("seq reset mid-drain: outputs cleared");

    run_job(tbl[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
